// File: rtl/sdram_pattern_tester_if.sv
// Byte-wide access bus between the pattern tester and the dual-port SDRAM controller
// (write strobe/data on port B, read strobe/data on port A).
interface sdram_pattern_tester_if;
  logic        mem_we;
  logic        mem_oe;
  logic [24:0] mem_addr;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;

  modport master (output mem_we, output mem_oe, output mem_addr, output mem_din, input mem_dout);
  modport slave  (input mem_we, input mem_oe, input mem_addr, input mem_din, output mem_dout);
endinterface

// File: rtl/sdram_pattern_tester.sv
// Slot-paced memory tester: writes a(7:0)+pass pattern over 0..2^ADDR_W-1, reads it back,
// counts mismatches and latches the first failing address.
module sdram_pattern_tester #(
  parameter int ADDR_W = 8,
  parameter int LOOPS  = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           slot,
  sdram_pattern_tester_if.master         mem,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic [15:0]                    err_count,
  output logic [24:0]                    first_err_addr,
  output logic [7:0]                     loop_count
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, FLUSH, DONE} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [ADDR_W-1:0]   prev_addr_reg, prev_addr_next;
  logic                rd_pending_reg, rd_pending_next;
  logic                we_reg, we_next;
  logic                oe_reg, oe_next;
  logic [24:0]         mem_addr_reg, mem_addr_next;
  logic [7:0]          din_reg, din_next;
  logic [15:0]         err_reg, err_next;
  logic [24:0]         first_reg, first_next;
  logic [7:0]          loop_reg, loop_next;
  logic                cmp_en;

  function automatic logic [7:0] pattern(input logic [ADDR_W-1:0] a, input logic [7:0] p);
    return 8'(a) + p;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      prev_addr_reg  <= '0;
      rd_pending_reg <= 1'b0;
      we_reg         <= 1'b0;
      oe_reg         <= 1'b0;
      mem_addr_reg   <= '0;
      din_reg        <= '0;
      err_reg        <= '0;
      first_reg      <= '0;
      loop_reg       <= '0;
    end else begin
      state_reg      <= state_next;
      addr_reg       <= addr_next;
      prev_addr_reg  <= prev_addr_next;
      rd_pending_reg <= rd_pending_next;
      we_reg         <= we_next;
      oe_reg         <= oe_next;
      mem_addr_reg   <= mem_addr_next;
      din_reg        <= din_next;
      err_reg        <= err_next;
      first_reg      <= first_next;
      loop_reg       <= loop_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    addr_next       = addr_reg;
    prev_addr_next  = prev_addr_reg;
    rd_pending_next = rd_pending_reg;
    we_next         = 1'b0;
    oe_next         = 1'b0;
    mem_addr_next   = mem_addr_reg;
    din_next        = din_reg;
    err_next        = err_reg;
    first_next      = first_reg;
    loop_next       = loop_reg;
    cmp_en          = 1'b0;

    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next      = WRITE;
          addr_next       = '0;
          rd_pending_next = 1'b0;
          err_next        = '0;
          first_next      = '0;
          loop_next       = '0;
        end
      end
      WRITE: begin
        if (slot) begin
          we_next       = 1'b1;
          mem_addr_next = 25'(addr_reg);
          din_next      = pattern(addr_reg, loop_reg);
          addr_next     = addr_reg + ADDR_W'(1);
          if (addr_reg == '1) state_next = READ;
        end
      end
      READ: begin
        // Each slot checks the data returned for the read issued one slot earlier.
        if (slot) begin
          cmp_en          = rd_pending_reg;
          oe_next         = 1'b1;
          mem_addr_next   = 25'(addr_reg);
          prev_addr_next  = addr_reg;
          rd_pending_next = 1'b1;
          addr_next       = addr_reg + ADDR_W'(1);
          if (addr_reg == '1) state_next = FLUSH;
        end
      end
      FLUSH: begin
        if (slot) begin
          cmp_en          = 1'b1;
          rd_pending_next = 1'b0;
          loop_next       = loop_reg + 8'd1;
          addr_next       = '0;
          if (LOOPS == 0 || int'(loop_reg) + 1 < LOOPS) state_next = WRITE;
          else                                          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (cmp_en && (mem.mem_dout != pattern(prev_addr_reg, loop_reg))) begin
      if (err_reg != 16'hFFFF) err_next = err_reg + 16'd1;
      if (err_reg == 16'd0)    first_next = 25'(prev_addr_reg);
    end
  end

  assign mem.mem_we   = we_reg;
  assign mem.mem_oe   = oe_reg;
  assign mem.mem_addr = mem_addr_reg;
  assign mem.mem_din  = din_reg;

  assign busy           = (state_reg == WRITE) || (state_reg == READ) || (state_reg == FLUSH);
  assign done           = (state_reg == DONE);
  assign pass           = done && (err_reg == 16'd0);
  assign err_count      = err_reg;
  assign first_err_addr = first_reg;
  assign loop_count     = loop_reg;

endmodule
